// File: rtl/aes_256_job_scheduler_if.sv
// aes_256_job_scheduler_if: request, core and response signals of the AES-256 job scheduler
interface aes_256_job_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_plaintext;
   logic [NUM_REQ*256-1:0] req_key;
   logic                   core_start;
   logic [127:0]           core_plaintext;
   logic [255:0]           core_key;
   logic                   core_done;
   logic [127:0]           core_ciphertext;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [127:0]           rsp_ciphertext;
   logic                   rsp_error;
   logic                   busy;
   modport slave (
      input  req_valid, req_plaintext, req_key, core_done, core_ciphertext, rsp_ready,
      output req_ready, core_start, core_plaintext, core_key, rsp_valid, rsp_id, rsp_ciphertext,
             rsp_error, busy
   );
   modport master (
      output req_valid, req_plaintext, req_key, core_done, core_ciphertext, rsp_ready,
      input  req_ready, core_start, core_plaintext, core_key, rsp_valid, rsp_id, rsp_ciphertext,
             rsp_error, busy
   );
endinterface

// File: rtl/aes_256_job_scheduler.sv
// aes_256_job_scheduler: round-robin sharing of one iterative AES-256 core with a done watchdog
module aes_256_job_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W = $clog2(NUM_REQ),
   parameter int TIMEOUT = 256
) (
   input logic enable,
   input logic reset,
   aes_256_job_scheduler_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;
   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [127:0]    pt_q, pt_d, ct_q, ct_d;
   logic [255:0]    key_q, key_d;
   logic            err_q, err_d, gnt_vld;
   logic [ID_W:0]   idx;
   // round-robin search: scanning from the farthest offset down leaves the nearest valid requester as winner
   always_comb begin
      gnt_vld = 1'b0;
      gnt = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_q} + (ID_W+1)'(k);
         idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
         if (bus.req_valid[idx[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt = idx[ID_W-1:0];
         end
      end
   end
   // next state and datapath captures; each register holds unless its state updates it
   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      id_d = id_q;
      wd_d = wd_q;
      pt_d = pt_q;
      key_d = key_q;
      ct_d = ct_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (gnt_vld) begin
            pt_d = bus.req_plaintext[128*gnt +: 128];
            key_d = bus.req_key[256*gnt +: 256];
            id_d = gnt;
            state_d = LAUNCH;
         end
         LAUNCH: begin
            wd_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + 1'b1;
            if (bus.core_done) begin
               ct_d = bus.core_ciphertext;
               err_d = 1'b0;
               state_d = RESP;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               ct_d = '0;
               err_d = 1'b1;
               state_d = RESP;
            end
         end
         RESP: if (bus.rsp_ready) begin
            rr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; reset drops any job in flight
   always_ff @(posedge enable) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q <= '0;
         id_q <= '0;
         wd_q <= '0;
         pt_q <= '0;
         key_q <= '0;
         ct_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         id_q <= id_d;
         wd_q <= wd_d;
         pt_q <= pt_d;
         key_q <= key_d;
         ct_q <= ct_d;
         err_q <= err_d;
      end
   end
   assign bus.req_ready = (state_q == IDLE && gnt_vld && !reset) ? NUM_REQ'(1) << gnt : '0;
   assign bus.core_start = state_q == LAUNCH;
   assign bus.core_plaintext = pt_q;
   assign bus.core_key = key_q;
   assign bus.rsp_valid = state_q == RESP;
   assign bus.rsp_id = id_q;
   assign bus.rsp_ciphertext = ct_q;
   assign bus.rsp_error = err_q;
   assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_aes_256_job_scheduler.sv
// tb_aes_256_job_scheduler: scoreboard bench for the job scheduler driving a 14-cycle behavioural core
module tb_aes_256_job_scheduler;
   localparam int NUM_REQ = 4;
   localparam int ID_W = 2;
   localparam int TIMEOUT = 14;
   localparam int CORE_LAT = 14;
   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] SP_PT = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] SP_CT = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [127:0]    ct;
      logic            err;
   } rsp_t;
   logic enable = 1'b0;
   logic reset = 1'b1;
   int checks = 0, errors = 0, starts = 0, core_cnt = 0;
   bit core_dead = 1'b0;
   logic [127:0] core_res = '0;
   logic [127:0] pts [NUM_REQ];
   logic [255:0] keys [NUM_REQ];
   rsp_t exp_q [$];
   rsp_t got;
   aes_256_job_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
   aes_256_job_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .enable(enable),
      .reset(reset),
      .bus(bus)
   );
   always #5 enable = ~enable;
   // known AES vectors come from their standards; any other job uses a simple XOR stand-in
   function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [255:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      if (pt == SP_PT && key == SP_KEY) return SP_CT;
      return pt ^ key[127:0] ^ key[255:128];
   endfunction
   // behavioural core: one-cycle done 14 cycles after start, never when core_dead; ignores scheduler reset
   always @(posedge enable) begin
      bus.core_done <= 1'b0;
      bus.core_ciphertext <= '0;
      if (bus.core_start) begin
         starts <= starts + 1;
         core_cnt <= core_dead ? 0 : CORE_LAT - 1;
         core_res <= model_ct(bus.core_plaintext, bus.core_key);
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            bus.core_done <= 1'b1;
            bus.core_ciphertext <= core_res;
         end
      end
   end
   // monitor: req_ready never multi-hot; every accepted response matches the oldest expectation
   always @(negedge enable) begin
      if (!reset) begin
         checks++;
         if (!$onehot0(bus.req_ready)) begin
            errors++;
            $display("FAIL req_ready_onehot: got %b required at most one bit set", bus.req_ready);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            got = {bus.rsp_id, bus.rsp_ciphertext, bus.rsp_error};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got id=%0d ct=%h err=%0b required no response", got.id, got.ct, got.err);
            end else if (got !== exp_q[0]) begin
               errors++;
               $display("FAIL rsp: got id=%0d ct=%h err=%0b required id=%0d ct=%h err=%0b",
                        got.id, got.ct, got.err, exp_q[0].id, exp_q[0].ct, exp_q[0].err);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
      end
   end
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask
   task automatic chk_zero(input string name);
      chk({name, "_core_key"}, bus.core_key, '0);
      chk({name, "_core_pt"}, 256'(bus.core_plaintext), '0);
      chk({name, "_rsp_ct"}, 256'(bus.rsp_ciphertext), '0);
      chk({name, "_ctrl"}, 256'({bus.req_ready, bus.core_start, bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.busy}), '0);
   endtask
   task automatic set_req(input int i, input logic [127:0] pt, input logic [255:0] key);
      pts[i] = pt;
      keys[i] = key;
      bus.req_plaintext[128*i +: 128] = pt;
      bus.req_key[256*i +: 256] = key;
   endtask
   task automatic tick(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge enable);
         #1;
      end
   endtask
   // wait for a grant, check it went to id, queue the expected response and let the handshake edge pass
   task automatic grant(input int id, input bit push, input bit drop);
      int n = 0;
      rsp_t e;
      #1;
      while (bus.req_ready == '0 && n < 100) begin
         tick(1);
         n++;
      end
      chk("grant", 256'(bus.req_ready), 256'(NUM_REQ'(1) << id));
      e.id = ID_W'(id);
      e.ct = core_dead ? '0 : model_ct(pts[id], keys[id]);
      e.err = core_dead;
      if (push) exp_q.push_back(e);
      tick(1);
      if (drop) bus.req_valid[id] = 1'b0;
   endtask
   task automatic wait_rsp(output int n);
      n = 0;
      while (!bus.rsp_valid && n < 100) begin
         tick(1);
         n++;
      end
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin
         tick(1);
         n++;
      end
      chk("idle_reached", 256'(bus.busy), '0);
   endtask
   initial begin
      int n, s0;
      bus.req_valid = '0;
      bus.req_plaintext = '0;
      bus.req_key = '0;
      bus.rsp_ready = 1'b1;
      tick(3);
      reset = 1'b0;
      chk_zero("reset");
      // FIPS-197 vector on requester 0: latency is handshake cycle to RESP = 2 + core latency
      s0 = starts;
      set_req(0, FIPS_PT, FIPS_KEY);
      bus.req_valid[0] = 1'b1;
      grant(0, 1, 1);
      wait_rsp(n);
      chk("latency", 256'(n + 1), 256'(2 + CORE_LAT));
      wait_idle();
      chk("fips_starts", 256'(starts - s0), 256'd1);
      // SP800-38A vector on requester 2
      set_req(2, SP_PT, SP_KEY);
      bus.req_valid[2] = 1'b1;
      grant(2, 1, 1);
      wait_idle();
      // response back-pressure: everything holds for 10 cycles while another requester waits
      bus.rsp_ready = 1'b0;
      set_req(1, FIPS_PT, FIPS_KEY);
      bus.req_valid[1] = 1'b1;
      grant(1, 1, 1);
      wait_rsp(n);
      set_req(3, 128'h0f0e0d0c0b0a09080706050403020100, {8{32'hdeadbeef}});
      bus.req_valid[3] = 1'b1;
      s0 = starts;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         chk("hold_ctrl", 256'({bus.rsp_valid, bus.rsp_id, bus.rsp_error}), 256'({1'b1, 2'd1, 1'b0}));
         chk("hold_ct", 256'(bus.rsp_ciphertext), 256'(FIPS_CT));
         chk("hold_quiet", 256'({bus.req_ready, bus.core_start}), '0);
      end
      chk("hold_starts", 256'(starts - s0), '0);
      bus.req_valid[3] = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_idle();
      // all four requesters valid from reset: grants 0,1,2,3,0
      reset = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, {4{32'hc0de0000 + 32'(i)}}, {8{32'hbeef0000 + 32'(i)}});
      bus.req_valid = '1;
      tick(2);
      reset = 1'b0;
      grant(0, 1, 0);
      grant(1, 1, 0);
      grant(2, 1, 0);
      grant(3, 1, 0);
      grant(0, 1, 0);
      bus.req_valid = '0;
      wait_idle();
      // dead core: watchdog gives LAUNCH plus TIMEOUT waiting cycles, then an error response
      core_dead = 1'b1;
      set_req(2, 128'h1234, {8{32'h5a5a5a5a}});
      bus.req_valid[2] = 1'b1;
      grant(2, 1, 1);
      wait_rsp(n);
      chk("timeout_cycles", 256'(n), 256'(TIMEOUT + 1));
      wait_idle();
      core_dead = 1'b0;
      // reset mid-WAIT: job dropped, stale done ignored, round robin restarts at requester 0
      set_req(1, 128'h4321, {8{32'ha5a5a5a5}});
      bus.req_valid[1] = 1'b1;
      grant(1, 0, 1);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk_zero("wait_reset");
      for (int c = 0; c < 20; c++) begin
         tick(1);
         chk("stale_done_quiet", 256'({bus.busy, bus.core_start, bus.rsp_valid}), '0);
      end
      set_req(0, 128'h1111, {8{32'h22222222}});
      set_req(3, 128'h3333, {8{32'h44444444}});
      bus.req_valid = 4'b1001;
      grant(0, 1, 1);
      grant(3, 1, 1);
      wait_idle();
      tick(2);
      chk("queue_empty", 256'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL sim_timeout: got no finish required finish before 100000");
      $fatal(1);
   end
endmodule
